// File: rtl/wb_regfile.sv
// Writeback-side register file: EX/MEM and MEM/WB pipeline registers, a 32x32 array, and two forwarding read ports.
// Optional macro REGFILE_EX_FWD_EN adds forwarding from the live EX inputs to the read ports.
module wb_regfile_rdport #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                            re_i,
  input  logic [ADDR_W-1:0]               raddr_i,
`ifdef REGFILE_EX_FWD_EN
  input  logic                            ex_wreg_i,
  input  logic [ADDR_W-1:0]               ex_addr_i,
  input  logic [DATA_W-1:0]               ex_data_i,
`endif
  input  logic                            em_wreg_i,
  input  logic [ADDR_W-1:0]               em_addr_i,
  input  logic [DATA_W-1:0]               em_data_i,
  input  logic                            mw_wreg_i,
  input  logic [ADDR_W-1:0]               mw_addr_i,
  input  logic [DATA_W-1:0]               mw_data_i,
  input  logic [REG_NUM-1:0][DATA_W-1:0]  regs_i,
  output logic [DATA_W-1:0]               rdata_o
);
  // Youngest matching stage wins; r0 reads zero even with a pending write to it.
  always_comb begin
    rdata_o = '0;
    if (!re_i || raddr_i == '0) rdata_o = '0;
`ifdef REGFILE_EX_FWD_EN
    else if (ex_wreg_i && ex_addr_i == raddr_i) rdata_o = ex_data_i;
`endif
    else if (em_wreg_i && em_addr_i == raddr_i) rdata_o = em_data_i;
    else if (mw_wreg_i && mw_addr_i == raddr_i) rdata_o = mw_data_i;
    else rdata_o = regs_i[raddr_i];
  end
endmodule

module wb_regfile #(
  parameter int REG_NUM = 32,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ex_wd_addr_i,
  input  logic              ex_wreg_i,
  input  logic [DATA_W-1:0] ex_wdata_i,
  input  logic [1:0]        stall_i,
  input  logic              flush_i,
  input  logic              re1_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  output logic [DATA_W-1:0] rdata1_o,
  input  logic              re2_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata2_o,
  output logic [ADDR_W-1:0] wb_wd_addr_o,
  output logic              wb_wreg_o,
  output logic [DATA_W-1:0] wb_wdata_o
);
  localparam int NUM_RP = 2;

  typedef struct packed {
    logic              wreg;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t em_d, em_q, mw_d, mw_q, ex_ent;
  logic [REG_NUM-1:0][DATA_W-1:0] regs_q;

  assign ex_ent = '{wreg: ex_wreg_i, addr: ex_wd_addr_i, data: ex_wdata_i};

  // Any stall bit freezes EX/MEM, so 2'b10 behaves as 2'b11.
  always_comb begin
    em_d = em_q;
    if (flush_i)        em_d = '0;
    else if (|stall_i)  em_d = em_q;
    else                em_d = ex_ent;
  end

  // A stall on EX/MEM alone drains a bubble into MEM/WB rather than duplicating the entry.
  always_comb begin
    mw_d = mw_q;
    if (flush_i)          mw_d = '0;
    else if (stall_i[1])  mw_d = mw_q;
    else if (stall_i[0])  mw_d = '0;
    else                  mw_d = em_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      em_q <= '0;
      mw_q <= '0;
    end else begin
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  // Commit ignores flush and stall; a held MEM/WB entry just rewrites the same value.
  always_ff @(posedge clk) begin
    if (rst)                                  regs_q <= '0;
    else if (mw_q.wreg && mw_q.addr != '0)    regs_q[mw_q.addr] <= mw_q.data;
  end

  logic [NUM_RP-1:0]             rp_re;
  logic [NUM_RP-1:0][ADDR_W-1:0] rp_addr;
  logic [NUM_RP-1:0][DATA_W-1:0] rp_data;

  assign rp_re   = {re2_i, re1_i};
  assign rp_addr = {raddr2_i, raddr1_i};
  assign rdata1_o = rp_data[0];
  assign rdata2_o = rp_data[1];

  for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
    wb_regfile_rdport #(.REG_NUM(REG_NUM), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rp (
      .re_i      (rp_re[p]),
      .raddr_i   (rp_addr[p]),
`ifdef REGFILE_EX_FWD_EN
      .ex_wreg_i (ex_wreg_i),
      .ex_addr_i (ex_wd_addr_i),
      .ex_data_i (ex_wdata_i),
`endif
      .em_wreg_i (em_q.wreg),
      .em_addr_i (em_q.addr),
      .em_data_i (em_q.data),
      .mw_wreg_i (mw_q.wreg),
      .mw_addr_i (mw_q.addr),
      .mw_data_i (mw_q.data),
      .regs_i    (regs_q),
      .rdata_o   (rp_data[p])
    );
  end

  assign wb_wd_addr_o = mw_q.addr;
  assign wb_wreg_o    = mw_q.wreg;
  assign wb_wdata_o   = mw_q.data;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, latency/forwarding, youngest-wins, r0, stall and flush/reset.
module tb_wb_regfile;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  ex_wd_addr_i;
  logic        ex_wreg_i;
  logic [31:0] ex_wdata_i;
  logic [1:0]  stall_i;
  logic        flush_i;
  logic        re1_i, re2_i;
  logic [4:0]  raddr1_i, raddr2_i;
  logic [31:0] rdata1_o, rdata2_o;
  logic [4:0]  wb_wd_addr_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;

  int n_cmp = 0;
  int n_err = 0;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .ex_wd_addr_i(ex_wd_addr_i), .ex_wreg_i(ex_wreg_i), .ex_wdata_i(ex_wdata_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .re1_i(re1_i), .raddr1_i(raddr1_i), .rdata1_o(rdata1_o),
    .re2_i(re2_i), .raddr2_i(raddr2_i), .rdata2_o(rdata2_o),
    .wb_wd_addr_o(wb_wd_addr_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_EX_FWD_EN
  localparam bit EXF = 1'b1;
`else
  localparam bit EXF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [4:0] a, input logic w, input logic [31:0] d);
    ex_wd_addr_i = a;
    ex_wreg_i    = w;
    ex_wdata_i   = d;
  endtask

  // Drive one read port, let it settle, compare.
  task automatic rd(input int p, input logic [4:0] a, input logic [31:0] exp, input string tag);
    if (p == 1) begin re1_i = 1'b1; raddr1_i = a; end
    else        begin re2_i = 1'b1; raddr2_i = a; end
    #1;
    chk(tag, (p == 1) ? rdata1_o : rdata2_o, exp);
  endtask

  initial begin
    rst = 1'b1; stall_i = 2'b00; flush_i = 1'b0;
    re1_i = 1'b0; re2_i = 1'b0; raddr1_i = '0; raddr2_i = '0;
    ex(5'd0, 1'b0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_wb_wreg", {31'b0, wb_wreg_o}, 32'h0);
    chk("rst_wb_addr", {27'b0, wb_wd_addr_o}, 32'h0);
    chk("rst_wb_data", wb_wdata_o, 32'h0);
    for (int r = 1; r < 32; r++) begin
      re1_i = 1'b1; raddr1_i = r[4:0];
      re2_i = 1'b1; raddr2_i = r[4:0];
      #1;
      chk($sformatf("rst_p1_r%0d", r), rdata1_o, 32'h0);
      chk($sformatf("rst_p2_r%0d", r), rdata2_o, 32'h0);
    end

    // Latency: r5 written in cycle 0, committed at edge 3.
    tick();
    ex(5'd5, 1'b1, 32'h0000_1234);
    rd(1, 5'd5, EXF ? 32'h0000_1234 : 32'h0, "r5_cyc0");
    tick(); ex(5'd0, 1'b0, 32'h0);
    rd(1, 5'd5, 32'h0000_1234, "r5_cyc1_em");
    tick();
    rd(1, 5'd5, 32'h0000_1234, "r5_cyc2_mw");
    chk("r5_wb_wreg", {31'b0, wb_wreg_o}, 32'h1);
    chk("r5_wb_addr", {27'b0, wb_wd_addr_o}, 32'd5);
    chk("r5_wb_data", wb_wdata_o, 32'h0000_1234);
    tick();
    rd(1, 5'd5, 32'h0000_1234, "r5_cyc3_arr");
    chk("r5_wb_wreg_after", {31'b0, wb_wreg_o}, 32'h0);

    // Youngest of three in-flight writes to r7 wins.
    ex(5'd7, 1'b1, 32'hAAAA_0001); tick();
    ex(5'd7, 1'b1, 32'hAAAA_0002); tick();
    ex(5'd7, 1'b1, 32'hAAAA_0003);
    rd(1, 5'd7, EXF ? 32'hAAAA_0003 : 32'hAAAA_0002, "r7_three_inflight");
    tick(); ex(5'd0, 1'b0, 32'h0);
    rd(1, 5'd7, 32'hAAAA_0003, "r7_em_over_mw");
    rd(2, 5'd7, 32'hAAAA_0003, "r7_p2_same");
    tick();
    rd(1, 5'd7, 32'hAAAA_0003, "r7_mw_over_arr");
    tick(); tick();
    rd(1, 5'd7, 32'hAAAA_0003, "r7_arr_final");

    // Writes to r0 never forward or commit.
    ex(5'd0, 1'b1, 32'hFFFF_FFFF);
    rd(1, 5'd0, 32'h0, "r0_cyc0");
    tick(); ex(5'd0, 1'b0, 32'h0);
    rd(1, 5'd0, 32'h0, "r0_cyc1");
    tick();
    rd(1, 5'd0, 32'h0, "r0_cyc2");
    chk("r0_wb_wreg", {31'b0, wb_wreg_o}, 32'h1);
    tick(); tick();
    rd(2, 5'd0, 32'h0, "r0_arr");
    re1_i = 1'b0; raddr1_i = 5'd5; #1;
    chk("re0_zero", rdata1_o, 32'h0);

    // EX/MEM stall with stall_i=01: bubbles drain into MEM/WB.
    ex(5'd9, 1'b1, 32'h0000_0055); tick();
    ex(5'd0, 1'b0, 32'h0); stall_i = 2'b01;
    rd(1, 5'd9, 32'h55, "r9_stall_c0");
    tick();
    chk("r9_stall_bubble1", {31'b0, wb_wreg_o}, 32'h0);
    rd(1, 5'd9, 32'h55, "r9_stall_c1");
    rd(2, 5'd5, 32'h0000_1234, "p2_indep_r5");
    tick();
    chk("r9_stall_bubble2", {31'b0, wb_wreg_o}, 32'h0);
    stall_i = 2'b00;
    rd(1, 5'd9, 32'h55, "r9_release");
    tick();
    chk("r9_mw_wreg", {31'b0, wb_wreg_o}, 32'h1);
    chk("r9_mw_addr", {27'b0, wb_wd_addr_o}, 32'd9);
    rd(1, 5'd9, 32'h55, "r9_mw");
    tick();
    chk("r9_once", {31'b0, wb_wreg_o}, 32'h0);
    rd(1, 5'd9, 32'h55, "r9_arr");

    // stall_i=10 must also freeze EX/MEM.
    ex(5'd10, 1'b1, 32'h0000_000A); tick();
    ex(5'd11, 1'b1, 32'h0000_000B); stall_i = 2'b10;
    tick();
    ex(5'd0, 1'b0, 32'h0);
    chk("s10_mw_hold_bubble", {31'b0, wb_wreg_o}, 32'h0);
    rd(1, 5'd10, 32'h0000_000A, "s10_r10_em");
    stall_i = 2'b00;
    tick();
    chk("s10_mw_addr", {27'b0, wb_wd_addr_o}, 32'd10);
    tick(); tick();
    rd(1, 5'd11, 32'h0, "s10_r11_dropped");
    rd(2, 5'd10, 32'h0000_000A, "s10_r10_arr");

    // Flush: r4 in MEM/WB still commits, r3 in EX/MEM is dropped.
    ex(5'd4, 1'b1, 32'h0000_0088); tick();
    ex(5'd3, 1'b1, 32'h0000_0077); tick();
    ex(5'd0, 1'b0, 32'h0);
    chk("fl_pre_wb_addr", {27'b0, wb_wd_addr_o}, 32'd4);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fl_wb_wreg", {31'b0, wb_wreg_o}, 32'h0);
    rd(1, 5'd4, 32'h0000_0088, "fl_r4_committed");
    rd(2, 5'd3, 32'h0, "fl_r3_dropped");
    tick();
    rd(2, 5'd3, 32'h0, "fl_r3_still0");

    // Reset with the same contents: nothing commits, rst beats flush and stall.
    ex(5'd14, 1'b1, 32'h0000_0088); tick();
    ex(5'd13, 1'b1, 32'h0000_0077); tick();
    ex(5'd0, 1'b0, 32'h0);
    rst = 1'b1; flush_i = 1'b1; stall_i = 2'b11;
    tick();
    rst = 1'b0; flush_i = 1'b0;
    chk("rst2_wb_wreg", {31'b0, wb_wreg_o}, 32'h0);
    rd(1, 5'd14, 32'h0, "rst2_r14");
    rd(2, 5'd13, 32'h0, "rst2_r13");
    rd(1, 5'd4, 32'h0, "rst2_r4_cleared");
    tick();
    stall_i = 2'b00;
    tick(); tick();
    rd(1, 5'd14, 32'h0, "rst2_r14_late");
    rd(2, 5'd7, 32'h0, "rst2_r7_cleared");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the execute-stage result interface.
- Latches each EX result (write address, write enable, write data) through the EX/MEM and MEM/WB pipeline registers, then commits it to a 32x32 general register file.
- Serves the decode stage's two read ports, forwarding from in-flight stages so a dependent instruction sees the newest value.
- Sits between the execute stage (writer) and the decode stage (reader).

Parameters:
- REG_NUM, 32, number of architectural registers; register 0 is hard-wired to zero.
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; log2(REG_NUM).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ex_wd_addr_i  in  ADDR_W  destination register of the EX result.
- ex_wreg_i  in  1  EX result is to be written.
- ex_wdata_i  in  DATA_W  EX result value.
- stall_i  in  2  bit0 holds the EX/MEM register; bit1 holds the MEM/WB register.
- flush_i  in  1  discards both pipeline registers.
- re1_i  in  1  read port 1 enable.
- raddr1_i  in  ADDR_W  read port 1 address.
- rdata1_o  out  DATA_W  read port 1 data (combinational).
- re2_i  in  1  read port 2 enable.
- raddr2_i  in  ADDR_W  read port 2 address.
- rdata2_o  out  DATA_W  read port 2 data (combinational).
- wb_wd_addr_o  out  ADDR_W  MEM/WB stage destination (commit monitor).
- wb_wreg_o  out  1  MEM/WB stage write enable.
- wb_wdata_o  out  DATA_W  MEM/WB stage data.

Behaviour:
- Reset:
  - Both pipeline registers cleared to bubble (addr 0, wreg 0, data 0).
  - All array entries cleared to 0.
  - wb_* outputs read 0.
  - rst dominates flush and stall, including when asserted mid-stream.
- EX/MEM register, per edge:
  - flush_i: load bubble.
  - else stall_i[0] or stall_i[1]: hold. stall_i=2'b10 is treated as 2'b11.
  - else: load ex_* inputs.
- MEM/WB register, per edge:
  - flush_i: load bubble.
  - else stall_i[1]: hold.
  - else stall_i[0]: load bubble; the stalled EX/MEM entry is not duplicated.
  - else: load EX/MEM contents.
- Commit, per edge:
  - When MEM/WB wreg=1 and addr!=0, array[addr] <= data.
  - Commit occurs even while stall_i[1]=1, so a held entry is rewritten with the same value (idempotent).
  - Commit is suppressed by rst, not by flush_i (flush affects only the pipeline registers).
- Latency:
  - A result presented on ex_* in cycle 0 is in EX/MEM after edge 1 and in MEM/WB after edge 2.
  - It is written to the array at edge 3 and readable from the array in cycle 3.
- Read port N, combinational, in priority order:
  - re=0: output 0.
  - addr=0: output 0, regardless of any pending write to r0.
  - EX input (ex_wreg_i=1 and addr match): ex_wdata_i. Only when REGFILE_EX_FWD_EN is defined.
  - EX/MEM entry with wreg=1 and addr match: its data.
  - MEM/WB entry with wreg=1 and addr match: its data.
  - Otherwise: array[addr].
  - Youngest in-flight match always wins when several stages target the same address.
- Both read ports are independent; same-address reads return identical data.
- Bubbles (wreg=0) never forward and never commit.

Optional Feature:
- Macro REGFILE_EX_FWD_EN.
- Defined:
  - Read ports also forward from the live ex_* inputs.
  - A back-to-back dependent instruction reads the correct value with zero stall.
- Undefined:
  - EX-input forwarding is removed; the combinational path from ex_wdata_i to rdata*_o does not exist.
  - A read in the same cycle as the producing EX result returns the older value (EX/MEM, MEM/WB or array).
  - The hazard logic must insert one stall.

Test Plan:
- Reset, then read r1..r31 on both ports -> all 0; wb_wreg_o=0.
- ex writes r5=0x0000_1234 in cycle 0, no stall -> array r5=0x1234 after edge 3. Read r5 in cycles 1 and 2 -> 0x1234 via EX/MEM and MEM/WB forwarding. Cycle 0 returns 0x1234 with REGFILE_EX_FWD_EN defined, else 0.
- Consecutive writes r7=0xAAAA_0001, then r7=0xAAAA_0002, then r7=0xAAAA_0003 -> while all three are in flight, port 1 reads r7 as the youngest value. Array r7 ends at 0xAAAA_0003.
- ex writes r0=0xFFFF_FFFF -> reads of r0 return 0 in every cycle; array r0 stays 0.
- r9=0x55 in EX/MEM, stall_i=2'b01 for 2 cycles -> EX/MEM holds, MEM/WB receives bubbles (wb_wreg_o=0). After release, r9 commits exactly once more down the pipe; read r9 returns 0x55 throughout.
- r3=0x77 in EX/MEM and r4=0x88 in MEM/WB, assert flush_i -> both registers become bubbles. r4 still commits at that edge; r3 never commits. rst asserted with the same contents -> neither commits and the array reads 0.
